column_onehot_encoder: RTL and testbench

//   Converts a 3-bit column index (000..NUM_COLS-1; 3'b111 = "no column") back into a
//   one-hot column-select vector. Drives the per-column drop-indicator LEDs.

---
 rtl/column_onehot_encoder_pkg.sv | 21 ++
 rtl/column_onehot_encoder_blink_timer.sv | 64 ++++++
 rtl/column_onehot_encoder.sv | 101 ++++++++++
 tb/tb_column_onehot_encoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/column_onehot_encoder_pkg.sv
// rtl/column_onehot_encoder_pkg.sv - shared column constants, FSM states and index helpers
// Purpose: constants and types shared by the column LED encoder and its blink timer.
//   COL_NONE          : index value meaning "no column" (clear request)
//   NUM_COLS_DEFAULT  : default board width
//   state_t           : encoder FSM states (ST_IDLE, ST_SHOW)
//   index_in_range()  : true when an index selects a real column
package column_onehot_encoder_pkg;

  localparam logic [2:0] COL_NONE         = 3'b111;
  localparam int         NUM_COLS_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  function automatic logic index_in_range(input logic [2:0] idx, input int num_cols);
    return int'(idx) < num_cols;
  endfunction

endpackage

// File: rtl/column_onehot_encoder_blink_timer.sv
// rtl/column_onehot_encoder_blink_timer.sv - hold-window and blink-phase counters
// Purpose: times one indicator window of HOLD_CYCLES cycles, split into blink
//   half-periods of BLINK_HALF cycles starting with the LED on.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   start      in   begin (or restart) a window; first window cycle follows this edge
//   clear      in   abort the current window
//   phase_on   out  current blink phase (1 = LED lit)
//   phase_flip out  the blink phase changes at the next edge
//   expired    out  this is the last cycle of the window
module column_onehot_encoder_blink_timer #(
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_HALF  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic phase_on,
  output logic phase_flip,
  output logic expired
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic          active;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;

  // hold_cnt counts window cycles from 0; the window ends when it reaches
  // HOLD_CYCLES-1, so it never needs to wrap.
  assign expired    = active && (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign phase_flip = active && (blink_cnt == BW'(BLINK_HALF - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active    <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b0;
    end else if (start) begin
      active    <= 1'b1;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (expired) begin
      active    <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b0;
    end else if (active) begin
      hold_cnt <= hold_cnt + HW'(1);
      if (phase_flip) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/column_onehot_encoder.sv
// rtl/column_onehot_encoder.sv - column index to blinking one-hot LED drive
// Purpose: accepts a column index over valid/ready, lights that column's LED
//   blinking for a fixed window, then returns to idle. COL_NONE clears the
//   window; indices NUM_COLS..6 are rejected with a one-cycle error pulse.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   col_valid  in   col_index presented this cycle
//   col_index  in   column index, COL_NONE = clear request
//   col_ready  out  encoder can accept (always, outside reset)
//   col_onehot out  registered one-hot LED drive
//   col_error  out  one-cycle pulse for a rejected index
//   busy       out  indicator window active
module column_onehot_encoder
  import column_onehot_encoder_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEFAULT,
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_HALF  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                col_valid,
  input  logic [2:0]          col_index,
  output logic                col_ready,
  output logic [NUM_COLS-1:0] col_onehot,
  output logic                col_error,
  output logic                busy
);

  state_t     state;
  logic [2:0] idx_reg;

  logic accept;
  logic accept_show;
  logic accept_none;
  logic accept_bad;
  logic phase_on;
  logic phase_flip;
  logic expired;
  logic phase_next;

  assign col_ready   = ~reset;
  assign accept      = col_valid & col_ready;
  assign accept_show = accept && index_in_range(col_index, NUM_COLS);
  assign accept_none = accept && (col_index == COL_NONE);
  assign accept_bad  = accept && !index_in_range(col_index, NUM_COLS) && (col_index != COL_NONE);

  // LED drive is registered, so it is computed from the phase the timer
  // will hold after this edge.
  assign phase_next = phase_on ^ phase_flip;

  column_onehot_encoder_blink_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .BLINK_HALF  (BLINK_HALF)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (accept_show),
    .clear      (accept_none),
    .phase_on   (phase_on),
    .phase_flip (phase_flip),
    .expired    (expired)
  );

  function automatic logic [NUM_COLS-1:0] onehot_of(input logic [2:0] idx);
    return NUM_COLS'(1) << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx_reg    <= '0;
      col_onehot <= '0;
      busy       <= 1'b0;
      col_error  <= 1'b0;
    end else begin
      // A rejected index only pulses the error; the window carries on below.
      col_error <= accept_bad;
      if (accept_show) begin
        state      <= ST_SHOW;
        idx_reg    <= col_index;
        col_onehot <= onehot_of(col_index);
        busy       <= 1'b1;
      end else if (accept_none) begin
        state      <= ST_IDLE;
        col_onehot <= '0;
        busy       <= 1'b0;
      end else if (state == ST_SHOW) begin
        if (expired) begin
          state      <= ST_IDLE;
          col_onehot <= '0;
          busy       <= 1'b0;
        end else begin
          col_onehot <= phase_next ? onehot_of(idx_reg) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_column_onehot_encoder.sv
// tb/tb_column_onehot_encoder.sv - scoreboard bench for column_onehot_encoder
module tb_column_onehot_encoder;

  localparam int NC   = 4;
  localparam int HOLD = 8;
  localparam int BH   = 2;

  typedef struct {
    logic [NC-1:0] onehot;
    logic          busy;
    logic          error;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          col_valid;
  logic [2:0]    col_index;
  logic          col_ready;
  logic [NC-1:0] col_onehot;
  logic          col_error;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  // reference model: a window is "column win_idx accepted at edge win_start"
  int   edge_no   = 0;
  bit   in_win    = 0;
  int   win_start = 0;
  int   win_idx   = 0;

  column_onehot_encoder #(
    .NUM_COLS    (NC),
    .HOLD_CYCLES (HOLD),
    .BLINK_HALF  (BH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_valid  (col_valid),
    .col_index  (col_index),
    .col_ready  (col_ready),
    .col_onehot (col_onehot),
    .col_error  (col_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs at the falling edge and predict the outputs
  // seen after the following rising edge
  task automatic step(input bit r, input bit v, input int idx);
    exp_t e;
    int   k;
    @(negedge clk);
    reset     = r;
    col_valid = v;
    col_index = 3'(idx);
    edge_no++;
    e.onehot = '0;
    e.busy   = 1'b0;
    e.error  = 1'b0;
    if (r) begin
      in_win = 0;
    end else if (v) begin
      if (idx < NC) begin
        in_win    = 1;
        win_start = edge_no;
        win_idx   = idx;
      end else if (idx == 7) begin
        in_win = 0;
      end else begin
        e.error = 1'b1;
      end
    end
    if (in_win) begin
      k = edge_no - win_start + 1;
      if (k > HOLD) in_win = 0;
      else begin
        e.busy = 1'b1;
        if (((k - 1) / BH) % 2 == 0) e.onehot = NC'(1 << win_idx);
      end
    end
    exp_q.push_back(e);
    #1;
    checks++;
    if (col_ready !== !r) begin
      failures++;
      $display("FAIL ready: got %b want %b", col_ready, !r);
    end
  endtask

  // monitor: compare every cycle for which an expectation exists
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (col_onehot !== e.onehot || busy !== e.busy || col_error !== e.error) begin
          failures++;
          $display("FAIL outputs edge %0d: got onehot=%b busy=%b err=%b want onehot=%b busy=%b err=%b",
                   edge_no, col_onehot, busy, col_error, e.onehot, e.busy, e.error);
        end
      end
    end
  end

  initial begin
    int waited;
    int r;
    reset     = 1'b1;
    col_valid = 1'b0;
    col_index = 3'd0;

    // reset held 3 cycles with a valid index present
    repeat (3) step(1, 1, 1);
    repeat (3) step(0, 0, 0);
    // single window, idx 2
    step(0, 1, 2);
    repeat (10) step(0, 0, 0);
    // restart with a new index
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 3);
    repeat (10) step(0, 0, 0);
    // rejected index in idle and mid-window
    step(0, 1, 5); step(0, 0, 0);
    step(0, 1, 1); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 6);
    repeat (8) step(0, 0, 0);
    // clear mid-window, then clear while idle
    step(0, 1, 1); step(0, 0, 0);
    step(0, 1, 7);
    repeat (2) step(0, 0, 0);
    step(0, 1, 7); step(0, 0, 0);
    // reset mid-window, then a fresh window
    step(0, 1, 3); repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 2);
    repeat (10) step(0, 0, 0);
    // same index re-sent restarts; accept on expiry cycle wins
    step(0, 1, 2); repeat (3) step(0, 0, 0); step(0, 1, 2);
    repeat (7) step(0, 0, 0); step(0, 1, 1);
    repeat (10) step(0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 2, r >= 2 && r < 35, int'($urandom_range(0, 7)));
    end
    repeat (3) step(0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
